// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling; UART_RX_MAJORITY_EN enables 2-of-3 majority bit decisions
module uart_rx #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       en_data_out,
  output logic       busy,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, bit_v, bit_done, good, bad;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  // two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge res)
    if (res) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {RX, rx_m};
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  // previous two synchronized samples; with rx_s they form the 3-sample decision window
  always_ff @(posedge clk or posedge res)
    if (res) hist <= 2'b11;
    else hist <= {hist[0], rx_s};
  assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif
  assign bit_done = cnt == BIT_END;
  assign good = state == STOP && bit_done && bit_v;
  assign bad = state == STOP && bit_done && !bit_v;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge res)
    if (res) state <= IDLE;
    else state <= state_n;
  // next-state decisions at the start-bit midpoint and at each bit centre
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   state_n = cnt == HALF_END ? (bit_v ? IDLE : DATA) : START;
      DATA:    state_n = bit_done && bit_idx == 3'd7 ? STOP : DATA;
      STOP:    state_n = bit_done ? (bit_v ? IDLE : BREAK) : STOP;
      BREAK:   state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  // bit timing, data shifting and result registers
  always_ff @(posedge clk or posedge res)
    if (res) begin
      cnt <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      data_out <= '0;
      en_data_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= (state_n != state || (state == DATA && bit_done)) ? '0 : cnt + 1'b1;
      bit_idx <= state == START ? 3'd0 : (state == DATA && bit_done) ? bit_idx + 3'd1 : bit_idx;
      shift_reg <= (state == DATA && bit_done) ? {bit_v, shift_reg[7:1]} : shift_reg;
      data_out <= good ? shift_reg : data_out;
      en_data_out <= good;
      frame_err <= good ? 1'b0 : bad ? 1'b1 : frame_err;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at a short bit period
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT = HALF + 9 * CPB + 2;
  logic clk = 1'b0, res = 1'b1, RX = 1'b1;
  logic [7:0] data_out;
  logic en_data_out, busy, frame_err;
  int n_checks = 0, n_fail = 0, cyc = 0, t0 = 0, both_high = 0;
  logic [7:0] exp_q[$], got_q[$];
  int lat_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .res(res), .RX(RX), .data_out(data_out),
    .en_data_out(en_data_out), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // capture every strobe just after the edge that raises it
  always @(posedge clk) begin
    #1;
    if (en_data_out) begin
      got_q.push_back(data_out);
      lat_q.push_back(cyc);
    end
    if (en_data_out && frame_err) both_high <= both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // drive start, data (LSB first) and stop; n_cyc truncates the frame, gl inverts RX for one clock at each data-bit centre
  task automatic send(input logic [7:0] b, input logic stop, input logic gl, input int n_cyc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CPB; c++) begin
        if (k * CPB + c >= n_cyc) return;
        @(negedge clk);
        if (k == 0 && c == 0) t0 = cyc;
        RX = (gl && k >= 1 && k <= 8 && c == HALF) ? ~f[k] : f[k];
      end
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n * 11 * CPB + 100 && got_q.size() < n; i++) @(negedge clk);
    check({tag, " strobes"}, got_q.size(), n);
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, " data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("reset data_out", data_out, 8'h00);
    check("reset en", en_data_out, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    res = 1'b0;
    repeat (4) @(negedge clk);
    // single good frame with latency and busy checks
    lat_q.delete();
    exp_q.push_back(8'h53);
    send(8'h53, 1'b1, 1'b0, 10 * CPB);
    RX = 1'b1;
    drain("0x53", 1);
    lat = lat_q.size() > 0 ? lat_q[0] - t0 - 1 : -1;
    n_checks++;
    assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
      n_fail++;
      $error("FAIL latency: observed %0d expected %0d +/-1", lat, LAT);
    end
    check("0x53 frame_err", frame_err, 1'b0);
    @(negedge clk);
    check("busy after strobe", busy, 1'b0);
    check("strobe one cycle", en_data_out, 1'b0);
    repeat (CPB) @(negedge clk);
    check("no extra strobe", got_q.size(), 0);
    // back-to-back frames with no idle gap
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    send(8'h00, 1'b1, 1'b0, 10 * CPB);
    send(8'hFF, 1'b1, 1'b0, 10 * CPB);
    send(8'hA5, 1'b1, 1'b0, 10 * CPB);
    RX = 1'b1;
    drain("b2b", 3);
    check("b2b frame_err", frame_err, 1'b0);
    // bad stop bit, then line held low (break)
    send(8'h3C, 1'b0, 1'b0, 10 * CPB);
    repeat (4 * CPB) @(negedge clk);
    check("break frame_err", frame_err, 1'b1);
    check("break busy", busy, 1'b1);
    check("break no strobe", got_q.size(), 0);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    check("break released busy", busy, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("break no false start", got_q.size(), 0);
    check("frame_err sticky", frame_err, 1'b1);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0, 10 * CPB);
    RX = 1'b1;
    drain("0x81", 1);
    check("0x81 clears frame_err", frame_err, 1'b0);
    // short low glitch rejected at the start-bit midpoint
    repeat (3) @(negedge clk) RX = 1'b0;
    @(negedge clk) RX = 1'b1;
    check("glitch busy", busy, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch idle", busy, 1'b0);
    check("glitch no strobe", got_q.size(), 0);
    check("glitch no flag", frame_err, 1'b0);
    // reset during data bit 4
    send(8'h5A, 1'b1, 1'b0, 5 * CPB + HALF);
    check("mid-frame busy", busy, 1'b1);
    res = 1'b1;
    #1;
    check("abort data_out", data_out, 8'h00);
    check("abort busy", busy, 1'b0);
    check("abort en", en_data_out, 1'b0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("abort no strobe", got_q.size(), 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0, 10 * CPB);
    RX = 1'b1;
    drain("0x5A", 1);
    // one-clock glitches at each data-bit centre
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h53);
`else
    exp_q.push_back(8'hAC);
`endif
    send(8'h53, 1'b1, 1'b1, 10 * CPB);
    RX = 1'b1;
    drain("centre glitch", 1);
    repeat (CPB) @(negedge clk);
    check("en with frame_err", both_high, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
